// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART program loader.
package uart_pkg;

    // Data bits per 8N1 frame (the frame adds one start and one stop bit).
    localparam int DATA_BITS = 8;

    // Loader FSM state encodings.
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_ARMED_ENC = 3'd1;
    localparam logic [2:0] ST_RECV_ENC  = 3'd2;
    localparam logic [2:0] ST_WRITE_ENC = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ARMED = ST_ARMED_ENC,
        ST_RECV  = ST_RECV_ENC,
        ST_WRITE = ST_WRITE_ENC,
        ST_DONE  = ST_DONE_ENC
    } ld_state_t;

    // Receiver framing states.
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // Clock cycles per bit, truncated.
    function automatic int calc_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 byte receiver: start-bit qualification at mid-bit, then one sample
// per bit period for 8 data bits (LSB first) and the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DIV = 86
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       rx_sync,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err_p
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Next-state: falling edge starts a frame, mid-bit recheck rejects glitches,
    // then a full bit period between each data sample and the stop sample.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        prev_d  = rx_sync;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (prev_q && !rx_sync) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_sync ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync, shift_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    valid_d = rx_sync;
                    ferr_d  = !rx_sync;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
        if (clr) begin
            state_d = RX_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
        end
    end

    // Receiver registers; line history resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            prev_q  <= 1'b1;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            prev_q  <= prev_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid  = valid_q;
    assign byte_data   = shift_q;
    assign frame_err_p = ferr_q;

endmodule

// File: rtl/uart_prog_loader.sv
// UART program loader: packs received bytes little-endian into 32-bit words
// and writes them to consecutive word addresses, ending on line idle.
module uart_prog_loader
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 10_000_000,
    parameter int BAUD         = 115200,
    parameter int ADDR_W       = 14,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              load_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic              overflow,
    output logic [ADDR_W:0]   word_cnt
);

    localparam int DIV       = calc_div(CLK_HZ, BAUD);
    localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TO_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    logic rx_meta_q, rx_sync_q;
    logic byte_valid, frame_err_p, rx_clr;
    logic [7:0] byte_data;

    ld_state_t         state_q;
    logic              load_en_prev_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q, done_q, frame_err_q, overflow_q;
    logic [ADDR_W:0]   word_cnt_q;
    logic [1:0]        byte_idx_q;
    logic              full_q;   // last address has been written
    logic              flush_q;  // current WRITE is the final partial word
    logic [TO_W-1:0]   idle_cnt_q;

    // Two-flop synchroniser for the asynchronous serial line (idle high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Receiver is held clear whenever no load is in progress.
    assign rx_clr = (state_q == ST_IDLE) || (state_q == ST_DONE) || !load_en;

    uart_rx #(.DIV(DIV)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .clr        (rx_clr),
        .rx_sync    (rx_sync_q),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err_p(frame_err_p)
    );

    // Loader FSM with packer, idle timeout and address/overflow tracking.
    // The idle counter restarts on any low line level or byte event, so it
    // only accumulates while no frame is in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            load_en_prev_q <= 1'b0;
            mem_we_q       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            frame_err_q    <= 1'b0;
            overflow_q     <= 1'b0;
            word_cnt_q     <= '0;
            byte_idx_q     <= '0;
            full_q         <= 1'b0;
            flush_q        <= 1'b0;
            idle_cnt_q     <= '0;
        end else begin
            load_en_prev_q <= load_en;
            mem_we_q       <= 1'b0;
            if (state_q != ST_IDLE && !load_en) begin
                // Abort: drop any partial word; done keeps its value.
                state_q    <= ST_IDLE;
                busy_q     <= 1'b0;
                byte_idx_q <= '0;
                wdata_q    <= '0;
                flush_q    <= 1'b0;
                idle_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (load_en && !load_en_prev_q) begin
                            state_q     <= ST_ARMED;
                            done_q      <= 1'b0;
                            frame_err_q <= 1'b0;
                            overflow_q  <= 1'b0;
                            word_cnt_q  <= '0;
                            addr_q      <= '0;
                            byte_idx_q  <= '0;
                            wdata_q     <= '0;
                            full_q      <= 1'b0;
                            flush_q     <= 1'b0;
                            idle_cnt_q  <= '0;
                        end
                    end
                    ST_ARMED, ST_RECV: begin
                        if (state_q == ST_ARMED && !rx_sync_q) begin
                            busy_q <= 1'b1;
                        end
                        if (!rx_sync_q || byte_valid || frame_err_p) begin
                            idle_cnt_q <= '0;
                        end else if (state_q == ST_RECV) begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                        if (frame_err_p) begin
                            frame_err_q <= 1'b1;
                        end
                        if (byte_valid) begin
                            wdata_q[{byte_idx_q, 3'b000} +: 8] <= byte_data;
                            byte_idx_q <= byte_idx_q + 2'd1;
                            if (byte_idx_q == 2'd3) begin
                                state_q    <= ST_WRITE;
                                mem_we_q   <= !full_q;
                                overflow_q <= overflow_q | full_q;
                                flush_q    <= 1'b0;
                            end else begin
                                state_q <= ST_RECV;
                            end
                        end else if (state_q == ST_RECV && idle_cnt_q == TO_LAST &&
                                     (word_cnt_q != '0 || byte_idx_q != 2'd0)) begin
                            if (byte_idx_q != 2'd0) begin
                                state_q    <= ST_WRITE;
                                mem_we_q   <= !full_q;
                                overflow_q <= overflow_q | full_q;
                                flush_q    <= 1'b1;
                            end else begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (!full_q) begin
                            if (addr_q == ADDR_MAX) begin
                                full_q <= 1'b1;
                            end else begin
                                addr_q <= addr_q + 1'b1;
                            end
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                        byte_idx_q <= '0;
                        wdata_q    <= '0;
                        idle_cnt_q <= '0;
                        if (flush_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            flush_q <= 1'b0;
                        end else begin
                            state_q <= ST_RECV;
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: default instance plus a 4-word-memory instance.
module tb_uart_prog_loader;

  localparam int DIV    = 10_000_000 / 115200;
  // start-bit drive to strobe: 2 synchroniser cycles, half a bit to mid-start,
  // 9 bit periods to the stop sample, then 2 cycles to mem_we
  localparam int LAT    = 2 + DIV / 2 + 9 * DIV + 2;
  localparam int TO_CYC = 32 * DIV;

  logic clk = 1'b0;
  logic rst, rx, load_en, rx2, load_en2;
  logic mem_we, busy, done, frame_err, overflow;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [14:0] word_cnt;
  logic mem_we2, busy2, done2, frame_err2, overflow2;
  logic [1:0] mem_addr2;
  logic [31:0] mem_wdata2;
  logic [2:0] word_cnt2;

  logic [45:0] got_q[$];
  logic [45:0] got2_q[$];
  logic [45:0] exp_q[$];
  int we_cyc_q[$];
  int cyc = 0;
  int last_start;
  int n_checks, n_pass;
  bit exp_ovf;
  int exp_wc;

  uart_prog_loader dut (
    .clk(clk), .rst(rst), .rx(rx), .load_en(load_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .frame_err(frame_err), .overflow(overflow),
    .word_cnt(word_cnt)
  );

  uart_prog_loader #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .rx(rx2), .load_en(load_en2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .busy(busy2), .done(done2), .frame_err(frame_err2), .overflow(overflow2),
    .word_cnt(word_cnt2)
  );

  // clock / cycle count
  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // write monitor
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      got_q.push_back({mem_addr, mem_wdata});
      we_cyc_q.push_back(cyc);
    end
    if (mem_we2 === 1'b1) got2_q.push_back({12'd0, mem_addr2, mem_wdata2});
  end

  // ---------------- reference model ----------------
  // Accepted bytes -> words, byte k of a word at bits 8k+7:8k, missing
  // upper bytes zero; only the first 'slots' words get written.
  function automatic void model_load(input logic [7:0] b[$], input int slots);
    int nw;
    logic [31:0] w;
    exp_q.delete();
    nw = (b.size() + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      w = 32'd0;
      for (int k = 0; k < 4; k++)
        if (4 * i + k < b.size()) w = w | (32'(b[4 * i + k]) << (8 * k));
      if (i < slots) exp_q.push_back({14'(i), w});
    end
    exp_ovf = (nw > slots);
    exp_wc  = (nw < slots) ? nw : slots;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_rx(input int sel, input logic v);
    if (sel == 0) rx = v; else rx2 = v;
  endtask

  task automatic hold_bit(input int sel, input logic v);
    drive_rx(sel, v);
    wait_cyc(DIV);
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_v);
    @(posedge clk);
    #1;
    last_start = cyc;
    hold_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) hold_bit(sel, b[i]);
    hold_bit(sel, stop_v);
    drive_rx(sel, 1'b1);
  endtask

  task automatic arm(input int sel);
    @(posedge clk);
    #1;
    if (sel == 0) load_en = 1'b0; else load_en2 = 1'b0;
    wait_cyc(2);
    if (sel == 0) load_en = 1'b1; else load_en2 = 1'b1;
    wait_cyc(4);
  endtask

  task automatic disarm(input int sel);
    if (sel == 0) load_en = 1'b0; else load_en2 = 1'b0;
    wait_cyc(4);
  endtask

  task automatic clear_logs;
    got_q.delete();
    got2_q.delete();
    we_cyc_q.delete();
  endtask

  task automatic wait_done(input int sel, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int k = 0; k < TO_CYC + 3000; k++) begin
      @(negedge clk);
      if ((sel == 0 ? done : done2) === 1'b1) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    wait_cyc(3);
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, frame_err, overflow, word_cnt} !== '0) begin
      $display("FAIL reset_outputs: got %0h expected 0",
               {mem_we, mem_addr, mem_wdata, busy, done, frame_err, overflow, word_cnt});
    end else n_pass++;
    n_checks++;
    if ({mem_we2, mem_addr2, mem_wdata2, busy2, done2, frame_err2, overflow2, word_cnt2} !== '0) begin
      $display("FAIL reset_outputs_small: got %0h expected 0",
               {mem_we2, mem_addr2, mem_wdata2, busy2, done2, frame_err2, overflow2, word_cnt2});
    end else n_pass++;
    rst = 1'b0;
    wait_cyc(3);
  endtask

  task automatic test_single_word;
    logic [7:0] b[$];
    clear_logs();
    b = '{8'h13, 8'h05, 8'h10, 8'h00};
    arm(0);
    foreach (b[i]) send_byte(0, b[i], 1'b1);
    wait_cyc(20);
    model_load(b, 1 << 14);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL single_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    if (we_cyc_q.size() > 0) begin
      n_checks++;
      if (we_cyc_q[0] !== last_start + LAT)
        $display("FAIL single_latency: got %0d expected %0d", we_cyc_q[0] - last_start, LAT);
      else n_pass++;
    end
    n_checks++;
    if ({busy, done, word_cnt} !== {1'b1, 1'b0, 15'd1})
      $display("FAIL single_status: got %0h expected %0h", {busy, done, word_cnt}, {1'b1, 1'b0, 15'd1});
    else n_pass++;
    disarm(0);
  endtask

  task automatic test_multi_word_timeout;
    logic [7:0] b[$];
    bit ok;
    int at;
    clear_logs();
    for (int i = 0; i < 12; i++) b.push_back(8'($urandom_range(0, 255)));
    arm(0);
    foreach (b[i]) begin
      send_byte(0, b[i], 1'b1);
      wait_cyc($urandom_range(0, 200));
    end
    wait_done(0, ok, at);
    model_load(b, 1 << 14);
    n_checks++;
    if (!ok) $display("FAIL multi_done_wait: got done=0 expected done=1");
    else n_pass++;
    n_checks++;
    if (at < last_start + LAT + TO_CYC - 20 || at > last_start + LAT + TO_CYC + 20)
      $display("FAIL multi_timeout_len: got %0d expected about %0d", at - last_start, LAT + TO_CYC);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL multi_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL multi_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({busy, done, overflow, word_cnt} !== {1'b0, 1'b1, 1'b0, 15'(exp_wc)})
      $display("FAIL multi_status: got %0h expected %0h", {busy, done, overflow, word_cnt}, {1'b0, 1'b1, 1'b0, 15'(exp_wc)});
    else n_pass++;
    disarm(0);
  endtask

  task automatic test_partial_word;
    logic [7:0] b[$];
    bit ok;
    int at;
    clear_logs();
    b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    arm(0);
    foreach (b[i]) send_byte(0, b[i], 1'b1);
    wait_done(0, ok, at);
    model_load(b, 1 << 14);
    n_checks++;
    if (!ok) $display("FAIL partial_done_wait: got done=0 expected done=1");
    else n_pass++;
    n_checks++;
    if (at < last_start + LAT + TO_CYC - 20 || at > last_start + LAT + TO_CYC + 20)
      $display("FAIL partial_timeout_len: got %0d expected about %0d", at - last_start, LAT + TO_CYC);
    else n_pass++;
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL partial_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL partial_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({busy, word_cnt} !== {1'b0, 15'(exp_wc)})
      $display("FAIL partial_status: got %0h expected %0h", {busy, word_cnt}, {1'b0, 15'(exp_wc)});
    else n_pass++;
    disarm(0);
  endtask

  task automatic test_frame_error_glitch;
    logic [7:0] good[$];
    logic [7:0] bad;
    clear_logs();
    for (int i = 0; i < 4; i++) good.push_back(8'($urandom_range(0, 255)));
    bad = 8'($urandom_range(0, 255));
    arm(0);
    // 20-cycle low pulse, shorter than half a bit
    drive_rx(0, 1'b0);
    wait_cyc(20);
    drive_rx(0, 1'b1);
    wait_cyc(3 * DIV);
    n_checks++;
    if ({frame_err, 1'(got_q.size() != 0), word_cnt} !== '0)
      $display("FAIL glitch_ignored: got err=%0b writes=%0d cnt=%0d expected 0 0 0", frame_err, got_q.size(), word_cnt);
    else n_pass++;
    send_byte(0, good[0], 1'b1);
    send_byte(0, bad, 1'b0);
    wait_cyc(DIV);
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL frame_err_set: got %0b expected 1", frame_err);
    else n_pass++;
    for (int i = 1; i < 4; i++) send_byte(0, good[i], 1'b1);
    wait_cyc(20);
    model_load(good, 1 << 14);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL ferr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL ferr_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if (frame_err !== 1'b1) $display("FAIL frame_err_sticky: got %0b expected 1", frame_err);
    else n_pass++;
    disarm(0);
  endtask

  task automatic test_abort;
    logic [7:0] b[$];
    clear_logs();
    arm(0);
    send_byte(0, 8'($urandom_range(0, 255)), 1'b1);
    send_byte(0, 8'($urandom_range(0, 255)), 1'b1);
    disarm(0);
    wait_cyc(100);
    n_checks++;
    if ({1'(got_q.size() != 0), busy, done} !== 3'b000)
      $display("FAIL abort_state: got writes=%0d busy=%0b done=%0b expected 0 0 0", got_q.size(), busy, done);
    else n_pass++;
    for (int i = 0; i < 4; i++) b.push_back(8'($urandom_range(0, 255)));
    arm(0);
    foreach (b[i]) send_byte(0, b[i], 1'b1);
    wait_cyc(20);
    model_load(b, 1 << 14);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL rearm_count: got %0d expected %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rearm_word[%0d]: got %0h expected %0h", i, got_q[i], exp_q[i]);
      else n_pass++;
    end
    disarm(0);
  endtask

  task automatic test_overflow;
    logic [7:0] b[$];
    bit ok;
    int at;
    clear_logs();
    for (int i = 0; i < 20; i++) b.push_back(8'($urandom_range(0, 255)));
    arm(1);
    foreach (b[i]) send_byte(1, b[i], 1'b1);
    wait_done(1, ok, at);
    model_load(b, 4);
    n_checks++;
    if (!ok) $display("FAIL ovf_done_wait: got done=0 expected done=1");
    else n_pass++;
    n_checks++;
    if (got2_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d expected %0d", got2_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got2_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got2_q[i] !== exp_q[i]) $display("FAIL ovf_word[%0d]: got %0h expected %0h", i, got2_q[i], exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({overflow2, word_cnt2, busy2} !== {exp_ovf, 3'(exp_wc), 1'b0})
      $display("FAIL ovf_status: got %0h expected %0h", {overflow2, word_cnt2, busy2}, {exp_ovf, 3'(exp_wc), 1'b0});
    else n_pass++;
    disarm(1);
  endtask

  task automatic test_reset_midframe;
    clear_logs();
    arm(0);
    for (int i = 0; i < 5; i++) send_byte(0, 8'($urandom_range(1, 255)), 1'b1);
    @(posedge clk);
    #1;
    drive_rx(0, 1'b0);
    wait_cyc(200);
    n_checks++;
    if ({busy, word_cnt} !== {1'b1, 15'd1})
      $display("FAIL pre_reset_status: got %0h expected %0h", {busy, word_cnt}, {1'b1, 15'd1});
    else n_pass++;
    rst = 1'b1;
    #5;
    n_checks++;
    if ({mem_we, mem_addr, mem_wdata, busy, done, frame_err, overflow, word_cnt} !== '0)
      $display("FAIL async_reset: got %0h expected 0",
               {mem_we, mem_addr, mem_wdata, busy, done, frame_err, overflow, word_cnt});
    else n_pass++;
    drive_rx(0, 1'b1);
    load_en = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx2 = 1'b1;
    load_en = 1'b0;
    load_en2 = 1'b0;
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single_word();
    test_multi_word_timeout();
    test_partial_word();
    test_frame_error_glitch();
    test_abort();
    test_overflow();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
